// File: rtl/bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// bus_arb_pkg
//
// Shared definitions for the two-requester memory bus arbiter:
//   arb_state_t : arbiter FSM states
//   PORT_I/D    : requester identifiers (also the encoding of last_served/owner)
//   IM_PAGE     : address[31:12] of the SPI instruction flash page
//   DM_PAGE     : address[31:12] of the data RAM page
//------------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        REJECT = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [19:0] IM_PAGE = 20'h00000;
    localparam logic [19:0] DM_PAGE = 20'h00100;

endpackage

// File: rtl/bus_arbiter_if.sv
//------------------------------------------------------------------------------
// bus_arbiter_if
//
// Single-ported memory bus shared by instruction fetch and load/store.
//   readMem      : read strobe        (master -> slave)
//   writemem     : write strobe       (master -> slave)
//   addressBus   : byte address       (master -> slave)
//   dataBusIn    : write data         (master -> slave)
//   memDataReady : completion         (slave  -> master)
//   dataBusOut   : read data          (slave  -> master)
// The arbiter connects to the master modport, the memory side to slave.
//------------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 32
);

    logic                     readMem;
    logic                     writemem;
    logic [ADDRESS_WIDTH-1:0] addressBus;
    logic [DATA_WIDTH-1:0]    dataBusIn;
    logic                     memDataReady;
    logic [DATA_WIDTH-1:0]    dataBusOut;

    modport master (
        output readMem,
        output writemem,
        output addressBus,
        output dataBusIn,
        input  memDataReady,
        input  dataBusOut
    );

    modport slave (
        input  readMem,
        input  writemem,
        input  addressBus,
        input  dataBusIn,
        output memDataReady,
        output dataBusOut
    );

endinterface

// File: rtl/bus_arbiter_timeout.sv
//------------------------------------------------------------------------------
// bus_timeout_counter
//
// Stall counter for a bus access. Only instantiated when BUS_TIMEOUT_EN is
// defined.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : restart counting from zero (asserted on entry to ACCESS)
//   enable  : count this cycle (access stalled, no ready)
//   expired : counter has reached LIMIT-1
// The count freezes once expired so it cannot wrap if the owner lingers.
//------------------------------------------------------------------------------
module bus_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] r_count;

    assign expired = (r_count == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
//------------------------------------------------------------------------------
// bus_arbiter
//
// Shares one memory bus (SPI flash below 0x0000_1000, data RAM at
// 0x0010_0000-0x0010_0FFF) between instruction fetch (port I) and
// load/store (port D). One transaction in flight; round-robin on ties.
//
// Build option:
//   BUS_TIMEOUT_EN : when defined, an ACCESS stalled for TIMEOUT_CYCLES
//                    cycles is aborted with err = 1 and rdata = 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req, i_addr                 fetch request (level) and address
//   i_gnt                         pulse: i_addr captured this cycle
//   i_done, i_err, i_rdata        completion pulse, error, fetched byte
//   d_req, d_we, d_addr, d_wdata  load/store request, direction, address, data
//   d_gnt, d_done, d_err, d_rdata as for port I
//   bus (master modport)          readMem, writemem, addressBus, dataBusIn,
//                                 memDataReady, dataBusOut
//
// Timing: gnt in the IDLE cycle (combinational, so the requester only has to
// hold its fields in that cycle), ACCESS from the next cycle, done visible in
// the DONE cycle that follows the first memDataReady.
//------------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     i_req,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    output logic                     i_gnt,
    output logic                     i_done,
    output logic [DATA_WIDTH-1:0]    i_rdata,
    output logic                     i_err,

    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_gnt,
    output logic                     d_done,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     d_err,

    bus_arbiter_if.master            bus
);

    arb_state_t                      r_state;
    logic                            r_last_served;
    logic                            r_owner;
    logic                            r_read;
    logic                            r_write;
    logic [ADDRESS_WIDTH-1:0]        r_bus_addr;
    logic [DATA_WIDTH-1:0]           r_bus_wdata;
    // Per-port result registers, indexed by PORT_I / PORT_D.
    logic [1:0]                      r_done;
    logic [1:0]                      r_err;
    logic [1:0][DATA_WIDTH-1:0]      r_rdata;

    logic                            w_any_req;
    logic                            w_win;
    logic                            w_win_we;
    logic [ADDRESS_WIDTH-1:0]        w_win_addr;
    logic [DATA_WIDTH-1:0]           w_win_wdata;
    logic                            w_reject;
    logic                            w_grant;
    logic                            w_timeout;

    //--------------------------------------------------------------------------
    // Arbitration. D wins when it is the only requester, or on a tie when I
    // was served last; otherwise I wins.
    //--------------------------------------------------------------------------
    assign w_any_req   = i_req | d_req;
    assign w_win       = d_req & (~i_req | (r_last_served == PORT_I));
    assign w_win_we    = (w_win == PORT_D) ? d_we : 1'b0;
    assign w_win_addr  = (w_win == PORT_D) ? d_addr : i_addr;
    assign w_win_wdata = (w_win == PORT_D) ? d_wdata : '0;

    // Stores into the flash page are refused without touching the bus.
    assign w_reject = w_win_we && (w_win_addr[ADDRESS_WIDTH-1 -: 20] == IM_PAGE);

    // No grant is offered while reset is applied: nothing would be captured.
    assign w_grant = (r_state == IDLE) && w_any_req && !rst;
    assign i_gnt   = w_grant && (w_win == PORT_I);
    assign d_gnt   = w_grant && (w_win == PORT_D);

    //--------------------------------------------------------------------------
    // Optional stall timeout.
    //--------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
    logic w_enter_access;
    logic w_stalled;
    logic w_to_expired;

    assign w_enter_access = w_grant && !w_reject;
    assign w_stalled      = (r_state == ACCESS) && !bus.memDataReady;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_enter_access),
        .enable  (w_stalled),
        .expired (w_to_expired)
    );

    assign w_timeout = w_to_expired;
`else
    assign w_timeout = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Control FSM. Bus strobes/address/data are registered and are non-zero
    // only while in ACCESS; done/err are one-cycle pulses shown in DONE.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_served <= PORT_I;
            r_owner       <= PORT_I;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_done        <= '0;
            r_err         <= '0;
            r_rdata       <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_win;
                        // Every granted transaction ends in DONE unless reset
                        // intervenes (which restores the reset value anyway),
                        // so recording the winner here is equivalent to
                        // recording it at completion.
                        r_last_served <= w_win;
                        if (w_reject) begin
                            r_state <= REJECT;
                        end else begin
                            r_state     <= ACCESS;
                            r_read      <= ~w_win_we;
                            r_write     <= w_win_we;
                            r_bus_addr  <= w_win_addr;
                            r_bus_wdata <= w_win_wdata;
                        end
                    end
                end

                ACCESS: begin
                    if (bus.memDataReady) begin
                        if (!r_write) begin
                            r_rdata[r_owner] <= bus.dataBusOut;
                        end
                        r_done[r_owner] <= 1'b1;
                        r_state         <= DONE;
                        r_read          <= 1'b0;
                        r_write         <= 1'b0;
                        r_bus_addr      <= '0;
                        r_bus_wdata     <= '0;
                    end else if (w_timeout) begin
                        r_rdata[r_owner] <= '0;
                        r_done[r_owner]  <= 1'b1;
                        r_err[r_owner]   <= 1'b1;
                        r_state          <= DONE;
                        r_read           <= 1'b0;
                        r_write          <= 1'b0;
                        r_bus_addr       <= '0;
                        r_bus_wdata      <= '0;
                    end
                end

                REJECT: begin
                    r_done[r_owner] <= 1'b1;
                    r_err[r_owner]  <= 1'b1;
                    r_state         <= DONE;
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.readMem    = r_read;
    assign bus.writemem   = r_write;
    assign bus.addressBus = r_bus_addr;
    assign bus.dataBusIn  = r_bus_wdata;

    assign i_done  = r_done[PORT_I];
    assign i_err   = r_err[PORT_I];
    assign i_rdata = r_rdata[PORT_I];
    assign d_done  = r_done[PORT_D];
    assign d_err   = r_err[PORT_D];
    assign d_rdata = r_rdata[PORT_D];

endmodule
